pipelined_addsub: RTL
=====================

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 SHALL have parameter N, default 24, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 3, pipeline depth; N mod STAGES = 0, STAGES >= 1, slice width W = N/STAGES.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 A  input  N  first operand.
REQ-008 B  input  N  second operand.
REQ-009 op  input  2  operation code; encoding in REQ-014.
REQ-010 C_in  input  1  external carry, used by ADC/SBC only.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 R, N_flag, Z_flag, C_flag, V_flag  output  N,1,1,1,1  result and flags.

Function
REQ-014 op encoding: 00 ADD = A+B; 01 SUB = A+~B+1; 10 ADC = A+B+C_in; 11 SBC = A+~B+C_in.
REQ-015 Effective B (B_eff) and carry-in SHALL be resolved in stage 0 from op; no later stage reads op.
REQ-016 Carry chain SHALL be split into STAGES slices of W bits; stage k adds slice k and registers its carry-out for stage k+1; less-significant result slices travel in skew registers alongside.
REQ-017 Latency SHALL be exactly STAGES cycles from accepted input to out_valid, absent stalls.
REQ-018 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-019 Global advance enable en = !out_valid || out_ready; in_ready SHALL equal en; all stages and valid bits update only when en.
REQ-020 Beat accepted iff in_valid && in_ready; a stage with valid=0 is a bubble; bubbles are not compressed.
REQ-021 out_valid, R and flags SHALL hold stable while out_valid && !out_ready.
REQ-022 N_flag = R[N-1]; Z_flag = 1 iff all N bits of R are 0.
REQ-023 C_flag = carry out of bit N-1 (for SUB/SBC, 1 means no borrow).
REQ-024 V_flag = (A[N-1] == B_eff[N-1]) && (R[N-1] != A[N-1]); A[N-1] and B_eff[N-1] SHALL be carried down the pipeline for this.
REQ-025 Flags SHALL be computed in the final stage from registered data and be valid in the same cycle as R.
REQ-026 Results SHALL emerge in acceptance order; no beat dropped or duplicated under any out_ready pattern.
REQ-027 Simultaneous output handshake and input acceptance in one cycle SHALL both complete.

Reset
REQ-028 On rst high, all valid bits, R and flags SHALL clear to 0 immediately, independent of clk.
REQ-029 in_ready SHALL read 1 during and after reset (pipeline empty, out_valid=0).
REQ-030 Beats in flight at reset SHALL be discarded; first beat accepted after deassertion SHALL appear after exactly STAGES cycles.

Structure
REQ-031 Package addsub_pkg SHALL hold the op enum (OP_ADD, OP_SUB, OP_ADC, OP_SBC) and a stage-payload struct type.
REQ-032 One sub-module addsub_slice SHALL implement a W-bit adder with carry in/out, instantiated once per stage via generate.
REQ-033 Parameter legality (N mod STAGES) SHALL be checked at elaboration with a fatal error.

Verification (N=24, STAGES=3)
REQ-034 ADD 0x7FFFFF + 0x000001 -> after 3 cycles R=0x800000, N=1, Z=0, C=0, V=1.
REQ-035 SUB 0x000005 - 0x000005 -> R=0x000000, Z=1, C=1, V=0, N=0.
REQ-036 ADC 0xFFFFFF + 0x000000, C_in=1 -> R=0x000000, Z=1, C=1, V=0.
REQ-037 Stream 8 back-to-back SUB beats, out_ready low on cycles 4-6 -> in_ready low those cycles, output held stable, all 8 results in order, none lost.
REQ-038 Assert rst with 2 beats in flight -> out_valid=0 at once; new beat SBC 0x000010 - 0x000001, C_in=1 -> R=0x00000F, C=1 after 3 cycles.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: op encoding and per-stage control payload shared by pipelined_addsub
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_t;

    // Control travelling with each beat: valid bit and carry into the next slice
    typedef struct packed {
        logic v;
        logic c;
    } stage_t;

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: W-bit ripple slice of the pipelined carry chain
// Ports: i_a/i_b slice operands, i_ci carry in, o_s slice sum, o_co carry out
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co
);

    assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep carry-split adder/subtractor with valid/ready flow control and NZCV flags
// Ports: clk/rst (async, active-high); in_valid/in_ready + A, B, op, C_in operand beat;
//        out_valid/out_ready + R, N_flag, Z_flag, C_flag, V_flag result beat
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int N      = 24,
    parameter int STAGES = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   op,
    input  logic         C_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] R,
    output logic         N_flag,
    output logic         Z_flag,
    output logic         C_flag,
    output logic         V_flag
);

    localparam int W = (STAGES < 1) ? N : N / STAGES;

    if (STAGES < 1 || N % STAGES != 0) begin : g_bad_params
        $fatal(1, "pipelined_addsub: N must be a multiple of STAGES and STAGES >= 1");
    end

    // Per-stage inputs: w_*[k] is what stage k consumes (stage 0 from ports, stage k from register k-1)
    logic [N-1:0] w_a   [STAGES];
    logic [N-1:0] w_b   [STAGES];
    logic [N-1:0] w_r   [STAGES];
    stage_t       w_ctl [STAGES];
    logic         w_en;
    op_t          w_op;

    // One global enable: the whole pipe freezes while a result sits unconsumed
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    assign w_op     = op_t'(op);

    // op is resolved here once; later stages only see B_eff and the carry
    assign w_a[0]   = A;
    assign w_b[0]   = (w_op == OP_SUB || w_op == OP_SBC) ? ~B : B;
    assign w_r[0]   = '0;
    assign w_ctl[0] = '{v: in_valid, c: (w_op == OP_ADD) ? 1'b0 : (w_op == OP_SUB) ? 1'b1 : C_in};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] w_s;
        logic         w_c;
        logic [N-1:0] w_sum;

        addsub_slice #(.W(W)) u_slice (
            .i_a (w_a[k][k*W +: W]),
            .i_b (w_b[k][k*W +: W]),
            .i_ci(w_ctl[k].c),
            .o_s (w_s),
            .o_co(w_c)
        );

        // Lower result slices arrive already filled; upper ones are still zero
        assign w_sum = w_r[k] | (N'(w_s) << (k * W));

        if (k < STAGES - 1) begin : g_mid
            // Full operands ride along so the final stage still sees A[N-1] and B_eff[N-1]
            logic [N-1:0] r_a;
            logic [N-1:0] r_b;
            logic [N-1:0] r_r;
            stage_t       r_ctl;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_r   <= '0;
                    r_ctl <= '0;
                end else if (w_en) begin
                    r_a   <= w_a[k];
                    r_b   <= w_b[k];
                    r_r   <= w_sum;
                    r_ctl <= '{v: w_ctl[k].v, c: w_c};
                end
            end

            assign w_a[k+1]   = r_a;
            assign w_b[k+1]   = r_b;
            assign w_r[k+1]   = r_r;
            assign w_ctl[k+1] = r_ctl;
        end else begin : g_last
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    R         <= '0;
                    N_flag    <= 1'b0;
                    Z_flag    <= 1'b0;
                    C_flag    <= 1'b0;
                    V_flag    <= 1'b0;
                end else if (w_en) begin
                    out_valid <= w_ctl[k].v;
                    R         <= w_sum;
                    N_flag    <= w_sum[N-1];
                    Z_flag    <= (w_sum == '0);
                    C_flag    <= w_c;
                    V_flag    <= (w_a[k][N-1] == w_b[k][N-1]) && (w_sum[N-1] != w_a[k][N-1]);
                end
            end
        end
    end

endmodule
